hazard_controller: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It detects load-use hazards that the forwarding unit cannot resolve and sequences the multi-cycle mul/div unit in EX. It also raises flush/bubble controls for taken branches resolved in EX. Its outputs drive the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/common_pkg.sv | 13 +
 rtl/hazard_controller_load_use.sv | 33 +++
 rtl/hazard_controller.sv | 115 +++++++++++
 tb/tb_hazard_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Types and defaults shared by the core's pipeline control blocks.
package common;

    typedef enum logic [0:0] {
        HZ_RUN     = 1'b0,
        HZ_MD_WAIT = 1'b1
    } hz_state_t;

    localparam int HZ_MD_TIMEOUT_DEFAULT = 64;
    localparam int HZ_REG_W_DEFAULT      = 6;
    localparam int HZ_CNT_W_DEFAULT      = 32;

endpackage

// File: rtl/hazard_controller_load_use.sv
// Load-use hazard detection: the EX load writes a register the ID instruction reads.
module load_use_detect #(
    parameter int REG_W = 6
) (
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    output logic             hazard
);

    logic [REG_W-1:0] src_id [2];
    logic [1:0]       src_used;
    logic [1:0]       src_match;

    assign src_id[0]   = rs1_id;
    assign src_id[1]   = rs2_id;
    assign src_used[0] = rs1_used;
    assign src_used[1] = rs2_used;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_match[gi] = src_used[gi] && (src_id[gi] == rd_ex);
        end
    endgenerate

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign hazard = mem_read_ex && (rd_ex != '0) && (|src_match);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush sequencing: load-use bubbles, mul/div issue-and-wait, branch flushes.
module hazard_controller
    import common::*;
#(
    parameter int REG_W      = HZ_REG_W_DEFAULT,
    parameter int MD_TIMEOUT = HZ_MD_TIMEOUT_DEFAULT,
    parameter int CNT_W      = HZ_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             rs1_used,
    input  logic             rs2_used,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    input  logic             muldiv_ex,
    input  logic             muldiv_done,
    input  logic             branch_taken_ex,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             muldiv_start,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MD_TIMEOUT - 1);

    hz_state_t        state_reg, state_next;
    logic [WC_W-1:0]  wait_cnt_reg, wait_cnt_next;
    logic             md_error_reg, md_error_next;
    logic [CNT_W-1:0] stall_count_reg;
    logic             load_use;
    logic [7:0]       ctrl_next;

    load_use_detect #(.REG_W(REG_W)) u_load_use (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used    (rs1_used),
        .rs2_used    (rs2_used),
        .rd_ex       (rd_ex),
        .mem_read_ex (mem_read_ex),
        .hazard      (load_use)
    );

    // ctrl_next: {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble,
    //             if_id_flush, id_ex_flush, ex_mem_bubble, muldiv_start}
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        md_error_next = md_error_reg;
        ctrl_next     = 8'b0;
        case (state_reg)
            HZ_RUN: begin
                if (branch_taken_ex) begin
                    ctrl_next = 8'b0000_1100;
                end else if (muldiv_ex) begin
                    ctrl_next     = 8'b1110_0011;
                    state_next    = HZ_MD_WAIT;
                    wait_cnt_next = '0;
                end else if (load_use) begin
                    ctrl_next = 8'b1101_0000;
                end
            end
            HZ_MD_WAIT: begin
                // Done cycle runs unstalled so the result can enter EX-MEM
                if (muldiv_done) begin
                    state_next = HZ_RUN;
                end else if (wait_cnt_reg == WC_LAST) begin
                    md_error_next = 1'b1;
                    state_next    = HZ_RUN;
                end else begin
                    ctrl_next     = 8'b1110_0010;
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            default: state_next = HZ_RUN;
        endcase
    end

    // Controls are held low for as long as reset is asserted, not just after the edge
    assign pc_stall      = ctrl_next[7] & reset_n;
    assign if_id_stall   = ctrl_next[6] & reset_n;
    assign id_ex_stall   = ctrl_next[5] & reset_n;
    assign id_ex_bubble  = ctrl_next[4] & reset_n;
    assign if_id_flush   = ctrl_next[3] & reset_n;
    assign id_ex_flush   = ctrl_next[2] & reset_n;
    assign ex_mem_bubble = ctrl_next[1] & reset_n;
    assign muldiv_start  = ctrl_next[0] & reset_n;
    assign md_error      = md_error_reg;
    assign stall_count   = stall_count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= HZ_RUN;
            wait_cnt_reg    <= '0;
            md_error_reg    <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            md_error_reg <= md_error_next;
            if (pc_stall && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with a scoreboard of expected control vectors.
module tb_hazard_controller;

    localparam int REG_W = 6;
    localparam int CNT_W = 8;
    localparam int TMO   = 64;

    logic             clk;
    logic             reset_n;
    logic [REG_W-1:0] rs1_id, rs2_id, rd_ex;
    logic             rs1_used, rs2_used, mem_read_ex, muldiv_ex, muldiv_done, branch_taken_ex;
    logic             pc_stall, if_id_stall, id_ex_stall, id_ex_bubble;
    logic             if_id_flush, id_ex_flush, ex_mem_bubble, muldiv_start, md_error;
    logic [CNT_W-1:0] stall_count;
    logic [7:0]       ctrl_bus;

    int vectors    = 0;
    int miscompares = 0;

    localparam logic [7:0] C_NONE  = 8'b0000_0000;
    localparam logic [7:0] C_LU    = 8'b1101_0000;
    localparam logic [7:0] C_FLUSH = 8'b0000_1100;
    localparam logic [7:0] C_START = 8'b1110_0011;
    localparam logic [7:0] C_HOLD  = 8'b1110_0010;

    typedef struct {
        string            tag;
        logic [7:0]       ctrl;
        logic             err;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    logic             exp_err;
    logic [CNT_W-1:0] exp_cnt;

    hazard_controller #(.REG_W(REG_W), .MD_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rs1_id          (rs1_id),
        .rs2_id          (rs2_id),
        .rs1_used        (rs1_used),
        .rs2_used        (rs2_used),
        .rd_ex           (rd_ex),
        .mem_read_ex     (mem_read_ex),
        .muldiv_ex       (muldiv_ex),
        .muldiv_done     (muldiv_done),
        .branch_taken_ex (branch_taken_ex),
        .pc_stall        (pc_stall),
        .if_id_stall     (if_id_stall),
        .id_ex_stall     (id_ex_stall),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .ex_mem_bubble   (ex_mem_bubble),
        .muldiv_start    (muldiv_start),
        .md_error        (md_error),
        .stall_count     (stall_count)
    );

    assign ctrl_bus = {pc_stall, if_id_stall, id_ex_stall, id_ex_bubble,
                       if_id_flush, id_ex_flush, ex_mem_bubble, muldiv_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [REG_W-1:0] rd, input logic [REG_W-1:0] r1,
                         input logic u1, input logic [REG_W-1:0] r2, input logic u2,
                         input logic mdx, input logic dn, input logic br);
        mem_read_ex = mr;  rd_ex = rd;
        rs1_id = r1; rs1_used = u1; rs2_id = r2; rs2_used = u2;
        muldiv_ex = mdx; muldiv_done = dn; branch_taken_ex = br;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock cycle: push expectation, compare mid-cycle, advance the model past the edge
    task automatic step(input string tag, input logic [7:0] exp_ctrl);
        exp_t e;
        e.tag = tag; e.ctrl = exp_ctrl; e.err = exp_err; e.cnt = exp_cnt;
        sb.push_back(e);
        @(negedge clk);
        e = sb.pop_front();
        $display("step %-12s ctrl=%b md_error=%b stall_count=%0d", e.tag, ctrl_bus, md_error, stall_count);
        chk({e.tag, ".ctrl"}, 32'(ctrl_bus), 32'(e.ctrl));
        chk({e.tag, ".err"},  32'(md_error), 32'(e.err));
        chk({e.tag, ".cnt"},  32'(stall_count), 32'(e.cnt));
        if (e.ctrl[7] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_run(input string tag);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step({tag, "_start"}, C_START);
        for (int i = 0; i < TMO - 1; i++) step({tag, "_hold"}, C_HOLD);
        step({tag, "_abort"}, C_NONE);
        exp_err = 1'b1;
        idle();
        step({tag, "_after"}, C_NONE);
    endtask

    initial begin
        exp_err = 1'b0;
        exp_cnt = '0;
        reset_n = 1'b0;
        drive(1, 5, 5, 1, 0, 0, 1, 0, 1);
        #12;
        chk("reset.ctrl", 32'(ctrl_bus), 32'(C_NONE));
        chk("reset.err",  32'(md_error), 32'd0);
        chk("reset.cnt",  32'(stall_count), 32'd0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        step("idle", C_NONE);
        drive(1, 5, 5, 1, 0, 0, 0, 0, 0); step("lu_rs1", C_LU);
        idle();                            step("lu_after", C_NONE);
        drive(1, 5, 3, 1, 5, 1, 0, 0, 0); step("lu_rs2", C_LU);
        drive(1, 0, 0, 1, 0, 1, 0, 0, 0); step("lu_rd0", C_NONE);
        drive(1, 5, 5, 0, 0, 0, 0, 0, 0); step("lu_unused", C_NONE);
        drive(0, 5, 5, 1, 5, 1, 0, 0, 0); step("lu_noload", C_NONE);
        drive(1, 6, 5, 1, 7, 1, 0, 0, 0); step("lu_nomatch", C_NONE);
        drive(1, 63, 63, 1, 0, 0, 0, 0, 0); step("lu_r63", C_LU);

        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); step("br", C_FLUSH);
        drive(1, 5, 5, 1, 0, 0, 0, 0, 1); step("br_lu", C_FLUSH);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 1); step("br_md", C_FLUSH);

        // mul/div with a load-use match at issue: mul/div takes priority
        drive(1, 5, 5, 1, 0, 0, 1, 0, 0); step("md_start", C_START);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) step("md_hold", C_HOLD);
        drive(1, 5, 5, 1, 0, 0, 1, 0, 1); step("md_hold_br", C_HOLD);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("md_hold", C_HOLD);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step("md_done", C_NONE);
        idle();                            step("md_after", C_NONE);
        step("md_cnt", C_NONE);

        // done pulse coinciding with launch is ignored
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step("md_early", C_START);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("md_e_hold", C_HOLD);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step("md_e_done", C_NONE);
        idle();                            step("md_e_after", C_NONE);

        timeout_run("tmo");
        for (int k = 0; k < 4; k++) timeout_run("sat");
        step("sat_cnt", C_NONE);

        // reset in the middle of a wait
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
        step("rst_start", C_START);
        step("rst_hold", C_HOLD);
        step("rst_hold", C_HOLD);
        reset_n = 1'b0;
        #2;
        chk("rst_mid.ctrl", 32'(ctrl_bus), 32'(C_NONE));
        chk("rst_mid.err",  32'(md_error), 32'd0);
        chk("rst_mid.cnt",  32'(stall_count), 32'd0);
        idle();
        exp_err = 1'b0;
        exp_cnt = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step("rst_idle", C_NONE);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0); step("rst_md", C_START);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 0); step("rst_md_done", C_NONE);
        idle();                            step("rst_after", C_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
